poly_mult_result_streamer: RTL

Consumer at the output end of the polynomial-multiplier systolic array. After a `start` pulse it waits out the array's fixed settling latency, then snapshots the wide product bus `p`. It streams the product coefficients one per handshake over a valid/ready port, lowest degree first. This block turns the parallel array result into the serial coefficient stream used by the downstream NTT/reduction datapath.

---
 rtl/poly_mult_pkg.sv | 32 +++
 rtl/poly_mult_result_streamer_if.sv | 21 ++
 rtl/poly_negacyclic_fold.sv | 18 +
 rtl/poly_mult_result_streamer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/poly_mult_pkg.sv
// Shared types and derivations for the polynomial-multiplier result streamer.
// Optional feature macro: POLY_NEGACYCLIC_FOLD_EN (negacyclic fold at capture).
package poly_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Coefficient width of the default build (2*N with N=16).
  localparam int COEF_W = 32;

  function automatic int coef_w_f(input int n);
    return 2 * n;
  endfunction

  // Number of coefficients that leave the block per product.
  function automatic int nc_f(input int d);
`ifdef POLY_NEGACYCLIC_FOLD_EN
    return d;
`else
    return 2 * d - 1;
`endif
  endfunction

  // Systolic array settling latency from start to a stable product bus.
  function automatic int lat_f(input int d);
    return 2 * d + 1;
  endfunction

endpackage

// File: rtl/poly_mult_result_streamer_if.sv
// Valid/ready coefficient stream carrying one product coefficient per transfer.
interface poly_mult_result_streamer_if #(
  parameter int CW = 32,
  parameter int IW = 5
);
  logic          coef_valid;
  logic          coef_ready;
  logic [CW-1:0] coef_data;
  logic [IW-1:0] coef_idx;
  logic          coef_last;

  modport master (
    output coef_valid, coef_data, coef_idx, coef_last,
    input  coef_ready
  );

  modport slave (
    input  coef_valid, coef_data, coef_idx, coef_last,
    output coef_ready
  );
endinterface

// File: rtl/poly_negacyclic_fold.sv
// Combinational reduction of a 2D-1 coefficient product modulo x^D+1.
// Only instantiated when POLY_NEGACYCLIC_FOLD_EN is defined.
module poly_negacyclic_fold #(
  parameter int D  = 16,
  parameter int CW = 32
) (
  input  logic [CW*(2*D-1)-1:0] raw,
  output logic [CW*D-1:0]       folded
);

  // x^(k+D) = -x^k, so upper coefficients subtract into the lower ones.
  for (genvar k = 0; k < D - 1; k++) begin : g_fold
    assign folded[k*CW +: CW] = raw[k*CW +: CW] - raw[(k+D)*CW +: CW];
  end

  assign folded[(D-1)*CW +: CW] = raw[(D-1)*CW +: CW];

endmodule

// File: rtl/poly_mult_result_streamer.sv
// Waits out the array latency after start, snapshots the product bus and streams
// its coefficients lowest degree first. Optional macro: POLY_NEGACYCLIC_FOLD_EN.
module poly_mult_result_streamer
  import poly_mult_pkg::*;
#(
  parameter int D   = 16,
  parameter int N   = 16,
  parameter int LAT = lat_f(D)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2*N*(2*D-1)-1:0]   p,
  output logic                     busy,
  poly_mult_result_streamer_if.master coef
);

  localparam int CW    = coef_w_f(N);
  localparam int NRAW  = 2 * D - 1;
  localparam int NC    = nc_f(D);
  localparam int IW    = $clog2(NRAW);
  localparam int CNT_W = $clog2(LAT + 1);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_WAIT   = S_WAIT;
  localparam logic [1:0] ST_STREAM = S_STREAM;

  logic [CW*NC-1:0] cap;

`ifdef POLY_NEGACYCLIC_FOLD_EN
  poly_negacyclic_fold #(
    .D  (D),
    .CW (CW)
  ) u_fold (
    .raw    (p),
    .folded (cap)
  );
`else
  assign cap = p;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [CW-1:0]    data_q,  data_d;
  logic             last_q,  last_d;
  logic [CW-1:0]    bank_q [NC];

  logic             capture;
  logic             xfer;
  logic [IW-1:0]    idx_inc;
  logic [CW-1:0]    bank_nxt;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    bank_nxt = '0;
    for (int i = 0; i < NC; i++) begin
      if (idx_inc == IW'(i)) bank_nxt = bank_q[i];
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    capture = 1'b0;
    xfer    = (state_q == ST_STREAM) && coef.coef_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_STREAM;
          idx_d   = '0;
          data_d  = cap[CW-1:0];
          last_d  = (NC == 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (idx_q == IW'(NC - 1)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_inc;
            data_d = bank_nxt;
            last_d = (idx_inc == IW'(NC - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // NOTE: the shadow bank has no reset; it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NC; i++) bank_q[i] <= cap[i*CW +: CW];
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign coef.coef_valid = (state_q == ST_STREAM);
  assign coef.coef_data  = data_q;
  assign coef.coef_idx   = idx_q;
  assign coef.coef_last  = last_q;

endmodule
